unpacked_stream_ser: RTL

UNPACKED_STREAM_SER -- requirements
Module: unpacked_stream_ser

---
 rtl/unpacked_stream_ser_pkg.sv | 25 ++
 rtl/unpacked_stream_unpack.sv | 22 ++
 rtl/unpacked_stream_ser.sv | 91 +++++++++
 3 files changed

// File: rtl/unpacked_stream_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : unpacked_stream_ser_pkg
// Brief   : Shared types and helpers for the unpacked stream serializer.
// Revision: 1.0 - initial release
// ============================================================================
package unpacked_stream_ser_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    DIR_MSB_FIRST = 1'b0,
    DIR_LSB_FIRST = 1'b1
  } dir_t;

  // Index width is never zero, so NE=1 still gets a usable 1-bit port.
  function automatic int idx_width(input int ne);
    return (ne <= 1) ? 1 : $clog2(ne);
  endfunction

endpackage
`default_nettype wire

// File: rtl/unpacked_stream_unpack.sv
`default_nettype none
// ============================================================================
// Module  : unpacked_stream_unpack
// Brief   : Splits a packed word into an array; element 0 is the MS slice.
// Revision: 1.0 - initial release
// ============================================================================
module unpacked_stream_unpack
  import unpacked_stream_ser_pkg::*;
#(
  parameter int EW = 4,
  parameter int NE = 5
) (
  input  logic [EW*NE-1:0] data,
  output logic [EW-1:0]    arr [NE]
);

  for (genvar i = 0; i < NE; i++) begin : g_elem
    assign arr[i] = data[(NE-1-i)*EW +: EW];
  end

endmodule
`default_nettype wire

// File: rtl/unpacked_stream_ser.sv
`default_nettype none
// ============================================================================
// Module  : unpacked_stream_ser
// Brief   : Serializes a packed word into NE elements, either order, with a
//           valid/ready handshake on both sides.
//           Define UNPACKED_STREAM_SER_BACK2BACK_EN for bubble-free reloads.
// Revision: 1.0 - initial release
// ============================================================================
module unpacked_stream_ser
  import unpacked_stream_ser_pkg::*;
#(
  parameter  int EW = 4,
  parameter  int NE = 5,
  localparam int IW = idx_width(NE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EW*NE-1:0]  in_data,
  input  logic              in_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EW-1:0]     out_data,
  output logic [IW-1:0]     out_idx,
  output logic              out_last
);

  localparam logic [IW-1:0] LAST_CNT = IW'(NE - 1);

  state_t        state_q, state_d;
  dir_t          dir_q;
  logic [IW-1:0] cnt_q;
  logic [EW-1:0] arr_q [NE];
  logic [EW-1:0] arr_d [NE];
  logic          load;
  logic          beat;

  unpacked_stream_unpack #(
    .EW (EW),
    .NE (NE)
  ) u_unpack (
    .data (in_data),
    .arr  (arr_d)
  );

  always_comb begin
    out_valid = (state_q == STREAM);
    out_last  = out_valid && (cnt_q == LAST_CNT);
    out_idx   = '0;
    out_data  = '0;
    if (out_valid) begin
      out_idx  = (dir_q == DIR_LSB_FIRST) ? (LAST_CNT - cnt_q) : cnt_q;
      out_data = arr_q[out_idx];
    end
`ifdef UNPACKED_STREAM_SER_BACK2BACK_EN
    // Accept the next word exactly when the final beat leaves.
    in_ready = !out_valid || (out_last && out_ready);
`else
    in_ready = !out_valid;
`endif
    load    = in_valid && in_ready;
    beat    = out_valid && out_ready;
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = STREAM;
      STREAM:  if (beat && out_last && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_MSB_FIRST;
      cnt_q   <= '0;
      for (int i = 0; i < NE; i++) arr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        arr_q <= arr_d;
        dir_q <= dir_t'(in_dir);
        cnt_q <= '0;
      end else if (beat && !out_last) begin
        cnt_q <= cnt_q + IW'(1);
      end
    end
  end

endmodule
`default_nettype wire
